// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of the async FIFO: pops narrow entries and packs LANES of them
// into one wide valid/ready word, with flush emitting a keep-masked partial word.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = $clog2(LANES) + 1
) (
  input  logic                   r_clk,
  input  logic                   r_rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_rd,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_last
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(LANES);

  logic [LANES-1:0][WIDTH-1:0] acc;
  logic [LANES-1:0][WIDTH-1:0] acc_n;
  logic [LANES-1:0][WIDTH-1:0] out_word;
  logic [CNT_W-1:0]            acc_cnt;
  logic [CNT_W-1:0]            cnt_cap;
  logic [LANES-1:0]            keep_n;
  logic                        rd_pend;
  logic                        flush_pend;
  logic                        out_free;
  logic                        full_now;
  logic                        drain;
  logic                        emit;
  logic                        flush_done;

  function automatic logic [LANES-1:0] lane_mask(input logic [CNT_W-1:0] cnt);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (CNT_W'(i) < cnt);
    return m;
  endfunction

  // cnt_cap is the lane count after this edge's capture; in-flight entries count as owned
  assign out_free   = !m_valid || m_ready;
  assign cnt_cap    = acc_cnt + CNT_W'(rd_pend);
  assign full_now   = (cnt_cap == FULL);
  assign drain      = flush_pend && !rd_pend;
  assign emit       = out_free && (full_now || (drain && acc_cnt != '0));
  assign flush_done = flush_pend && out_free && (full_now || drain);
  assign fifo_rd    = !r_rst && !fifo_empty && !flush_pend && (cnt_cap < FULL);
  assign keep_n     = lane_mask(cnt_cap);

  // Capturing entry bypasses into the outgoing word; unused lanes are zeroed
  always_comb begin
    acc_n    = acc;
    out_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rd_pend && acc_cnt == CNT_W'(i)) acc_n[i] = fifo_data;
      if (keep_n[i]) out_word[i] = acc_n[i];
    end
  end

  // Accumulator stage -> output register stage
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      acc        <= '0;
      acc_cnt    <= '0;
      rd_pend    <= 1'b0;
      flush_pend <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
      m_last     <= 1'b0;
    end else begin
      rd_pend <= fifo_rd;
      acc     <= acc_n;
      acc_cnt <= emit ? '0 : cnt_cap;
      if (flush_pend) flush_pend <= !flush_done;
      else            flush_pend <= flush;
      if (emit) begin
        m_valid <= 1'b1;
        m_data  <= out_word;
        m_keep  <= keep_n;
        m_last  <= flush_pend;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
